// File: rtl/ed25519_pkg.sv
// rtl/ed25519_pkg.sv - shared field-element types and arbiter state encoding
package ed25519_pkg;

  localparam int FE_W = 320;

  typedef logic signed [FE_W-1:0] fe_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic priority picker for shared-unit arbiters
module rr_pick
  import ed25519_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int LW = $clog2(N);

  logic [LW-1:0] cand;

  // Scan from the farthest slot back to last+1 so the nearest requester after last wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = LW'((int'(last) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fe_mul_arbiter.sv
// rtl/fe_mul_arbiter.sv - round-robin sharing of one fe_mul between NREQ sequencers
module fe_mul_arbiter
  import ed25519_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = FE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_f,
  input  logic [NREQ*W-1:0] req_g,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_h,
  output logic              mul_start,
  output logic [W-1:0]      mul_f,
  output logic [W-1:0]      mul_g,
  input  logic              mul_done,
  input  logic [W-1:0]      mul_h,
  output logic              busy,
  output logic [31:0]       op_count
);

  localparam int PW = $clog2(NREQ);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] pick_q, pick_d;
  logic [PW-1:0] last_q, last_d;
  logic [W-1:0]  mul_f_q, mul_f_d;
  logic [W-1:0]  mul_g_q, mul_g_d;
  logic [W-1:0]  resp_h_q, resp_h_d;
  logic [31:0]   op_count_q, op_count_d;

  logic          pick_any;
  logic [PW-1:0] pick_idx;

  rr_pick #(.N(NREQ)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    pick_d     = pick_q;
    last_d     = last_q;
    mul_f_d    = mul_f_q;
    mul_g_d    = mul_g_q;
    resp_h_d   = resp_h_q;
    op_count_d = op_count_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_ISSUE;
          pick_d  = pick_idx;
          mul_f_d = req_f[int'(pick_idx)*W +: W];
          mul_g_d = req_g[int'(pick_idx)*W +: W];
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      // Priority rotates only once the product is in hand, so an aborted op keeps its turn order.
      ARB_WAIT: begin
        if (mul_done) begin
          state_d    = ARB_RESP;
          resp_h_d   = mul_h;
          last_d     = pick_q;
          op_count_d = op_count_q + 32'd1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      pick_q     <= '0;
      last_q     <= PW'(NREQ - 1);
      mul_f_q    <= '0;
      mul_g_q    <= '0;
      resp_h_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pick_q     <= pick_d;
      last_q     <= last_d;
      mul_f_q    <= mul_f_d;
      mul_g_q    <= mul_g_d;
      resp_h_q   <= resp_h_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready  = (state_q == ARB_IDLE && pick_any) ? (NREQ'(1) << pick_idx) : '0;
  assign resp_valid = (state_q == ARB_RESP) ? (NREQ'(1) << pick_q) : '0;
  assign mul_start  = (state_q == ARB_ISSUE);
  assign busy       = (state_q != ARB_IDLE);
  assign mul_f      = mul_f_q;
  assign mul_g      = mul_g_q;
  assign resp_h     = resp_h_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb/tb_fe_mul_arbiter.sv - self-checking bench for fe_mul_arbiter with a latency-configurable fe_mul model
module tb_fe_mul_arbiter;
  import ed25519_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = FE_W;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_f     = '0;
  logic [NREQ*W-1:0] req_g     = '0;
  logic [NREQ-1:0]   req_ready, resp_valid;
  logic [W-1:0]      resp_h, mul_f, mul_g, mul_h;
  logic              mul_start, mul_done, busy;
  logic [31:0]       op_count;

  always #5 clk = ~clk;

  fe_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_f      (req_f),
    .req_g      (req_g),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_h     (resp_h),
    .mul_start  (mul_start),
    .mul_f      (mul_f),
    .mul_g      (mul_g),
    .mul_done   (mul_done),
    .mul_h      (mul_h),
    .busy       (busy),
    .op_count   (op_count)
  );

  // fe_mul model: done rises L cycles after the start cycle and stays high until the next start.
  int           lat = 5;
  int           mcnt;
  logic [W-1:0] prod_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt     <= 0;
      mul_done <= 1'b0;
      mul_h    <= '0;
      prod_q   <= '0;
    end else if (mul_start) begin
      mcnt     <= 1;
      mul_done <= 1'b0;
      mul_h    <= {(W/4){4'ha}};
      prod_q   <= mul_f * mul_g;
    end else if (mcnt != 0) begin
      if (mcnt == lat - 1) begin
        mcnt     <= 0;
        mul_done <= 1'b1;
        mul_h    <= prod_q;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] h;
  } exp_t;

  exp_t         sb[$];
  int           grants[$];
  logic [W-1:0] acc_f = '0;
  logic [W-1:0] acc_g = '0;
  int           gi;
  exp_t         e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        check("ready_onehot_valid", (($countones(req_ready) == 1) && ((req_ready & ~req_valid) == '0)), 1);
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
        acc_f = req_f[gi*W +: W];
        acc_g = req_g[gi*W +: W];
        sb.push_back('{gi, acc_f * acc_g});
        grants.push_back(gi);
      end
      if (busy) begin
        check("mul_f_stable", mul_f, acc_f);
        check("mul_g_stable", mul_g, acc_g);
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", resp_valid, 0);
        end else begin
          e = sb.pop_front();
          check("resp_route", resp_valid, NREQ'(1) << e.idx);
          check("resp_h", resp_h, e.h);
          check("resp_eq_mul_h", resp_h, mul_h);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = !busy && (sb.size() == 0);
    end
    check(name, ok, 1);
    tick();
  endtask

  task automatic run_one(input int idx, input logic [W-1:0] f, input logic [W-1:0] g, input int l,
                         output logic [W-1:0] h_o, output int cyc_o);
    bit ok;
    lat = l;
    req_f[idx*W +: W] = f;
    req_g[idx*W +: W] = g;
    req_valid[idx]    = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready[idx];
    end
    check("vec_accept", ok, 1);
    tick();
    req_valid[idx] = 1'b0;
    ok    = 1'b0;
    cyc_o = 0;
    h_o   = '0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      cyc_o++;
      ok  = resp_valid[idx];
      h_o = resp_h;
    end
    check("vec_resp_seen", ok, 1);
    tick();
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] f;
    logic [W-1:0] g;
    int           l;
    logic [W-1:0] h;
  } vec_t;

  vec_t         vecs[5];
  logic [W-1:0] ones, top, h;
  int           cyc;
  int           exp_ops = 0;
  bit           got;

  initial begin
    ones = '1;
    top  = '0;
    top[W-1] = 1'b1;
    vecs[0] = '{0, W'(1) << 200, W'(1) << 100, 2, W'(1) << 300};
    vecs[1] = '{1, W'(5), W'(6), 3, W'(30)};
    vecs[2] = '{2, top, W'(2), 6, W'(0)};
    vecs[3] = '{0, ones, ones, 4, W'(1)};
    vecs[4] = '{3, ones, W'(2), 2, ~W'(1)};

    #1;
    check("reset_busy", busy, 0);
    check("reset_start", mul_start, 0);
    check("reset_ready", req_ready, 0);
    check("reset_resp", resp_valid, 0);
    check("reset_mul_f", mul_f, 0);
    check("reset_mul_g", mul_g, 0);
    check("reset_resp_h", resp_h, 0);
    check("reset_op_count", op_count, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single request with exact cycle positions, L=5.
    lat = 5;
    req_f[2*W +: W] = W'(3);
    req_g[2*W +: W] = W'(7);
    req_valid[2]    = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("t1_ready", req_ready, (c == 0) ? 4'b0100 : 4'b0000);
      check("t1_start", mul_start, (c == 1));
      check("t1_resp", resp_valid, (c == 7) ? 4'b0100 : 4'b0000);
      check("t1_busy", busy, (c >= 1 && c <= 7));
      if (c == 7) check("t1_h", resp_h, W'(21));
      if (c == 8) check("t1_op_count", op_count, 1);
      tick();
      if (c == 0) req_valid[2] = 1'b0;
    end
    exp_ops = 1;

    // Vector table: varied requesters, latencies, signed and wrapping products.
    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i].idx, vecs[i].f, vecs[i].g, vecs[i].l, h, cyc);
      check("vec_h", h, vecs[i].h);
      check("vec_latency", cyc, vecs[i].l + 2);
      exp_ops++;
    end
    check("vec_op_count", op_count, exp_ops);

    // Fairness: all requesters valid continuously.
    lat = 3;
    for (int i = 0; i < NREQ; i++) begin
      req_f[i*W +: W] = W'(11 + i);
      req_g[i*W +: W] = W'(1000 + 7*i);
    end
    grants.delete();
    req_valid = '1;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      got = (grants.size() >= 6);
    end
    req_valid = '0;
    check("fair_grants_seen", got, 1);
    wait_idle("fair_drain");
    exp_ops += 6;
    check("fair_count", grants.size(), 6);
    for (int k = 0; k < 6 && k < grants.size(); k++) check("fair_order", grants[k], k % NREQ);
    check("fair_op_count", op_count, exp_ops);

    // Withdrawal: requester 1 raises and drops valid while the arbiter is busy.
    lat = 5;
    grants.delete();
    req_f[0 +: W] = W'(9);
    req_g[0 +: W] = W'(9);
    req_valid[0]  = 1'b1;
    @(negedge clk);
    check("wd_accept0", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    tick();
    req_valid[1] = 1'b1;
    tick();
    tick();
    req_valid[1] = 1'b0;
    wait_idle("wd_drain");
    repeat (3) tick();
    exp_ops++;
    check("wd_grants", grants.size(), 1);
    check("wd_op_count", op_count, exp_ops);

    // Operand stability: requester changes its operands during WAIT.
    grants.delete();
    req_f[3*W +: W] = W'(32'h1234);
    req_g[3*W +: W] = W'(16);
    req_valid[3]    = 1'b1;
    @(negedge clk);
    check("stab_accept", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    tick();
    tick();
    req_f[3*W +: W] = W'(32'hdead);
    req_g[3*W +: W] = W'(5);
    @(negedge clk);
    check("stab_mul_f", mul_f, W'(32'h1234));
    check("stab_mul_g", mul_g, W'(16));
    tick();
    wait_idle("stab_drain");
    exp_ops++;
    check("stab_h", resp_h, W'(32'h12340));
    check("stab_op_count", op_count, exp_ops);

    // Reset in cycle 3 of an operation.
    req_f[W +: W] = W'(77);
    req_g[W +: W] = W'(3);
    req_valid[1]  = 1'b1;
    @(negedge clk);
    check("rst_accept", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_start", mul_start, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_mul_f", mul_f, 0);
    check("rst_mul_g", mul_g, 0);
    check("rst_resp_h", resp_h, 0);
    check("rst_op_count", op_count, 0);
    sb.delete();
    grants.delete();
    exp_ops = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_no_resp", resp_valid, 0);
    end
    tick();
    req_f[0 +: W]   = W'(4);
    req_g[0 +: W]   = W'(5);
    req_f[3*W +: W] = W'(6);
    req_g[3*W +: W] = W'(7);
    req_valid = 4'b1001;
    rst_n     = 1'b1;
    @(negedge clk);
    check("rst_prio0", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      got = (grants.size() >= 2);
    end
    req_valid[3] = 1'b0;
    check("rst_second_grant", got, 1);
    wait_idle("rst_drain");
    exp_ops = 2;
    if (grants.size() >= 2) check("rst_grant3", grants[1], 3);
    check("rst_final_op_count", op_count, exp_ops);
    check("rst_final_h", resp_h, W'(42));

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
